fetch_exec_sequencer: RTL and testbench
=======================================

Name: fetch_exec_sequencer

Overview:
- Central instruction-cycle controller for the 8-bit RISC core.
- Steps a fixed 8-phase fetch/execute sequence and drives the select/hold controls of the 5-bit memory address multiplexer: data select, active/hold, skip, jump-target select.
- Also issues memory read/write, IR load, PC increment/load and accumulator load strobes.
- Stalls on a memory-ready handshake; handles HLT, SKZ and JMP.

Parameters:
- OP_W, 3, opcode width
- FETCH_WAIT_MAX, 15, max stall cycles per memory read before timeout flag

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  OP_W  IR opcode field (valid from phase INST_LOAD+1)
- zero  in  1  accumulator-zero flag
- mem_ready  in  1  memory read data valid this cycle
- resume  in  1  single-cycle pulse, leaves HALTED
- pc_addr  out  1  1 = mux selects data address
- pc_active  out  1  0 = mux holds previous address
- skip_signal  out  1  1 = mux selects jump/skip target
- skip  out  1  1 = force instruction address (SKZ taken)
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- ir_load  out  1  load instruction register
- pc_inc  out  1  increment PC
- pc_load  out  1  load PC from jump target
- acc_load  out  1  load accumulator from ALU
- halted  out  1  in HALTED state
- phase  out  3  current phase, for debug/trace
- mem_timeout  out  1  sticky, read stall exceeded FETCH_WAIT_MAX

Behaviour:
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7. ALU_OPS = {ADD, AND, XOR, LDA}.
- State register: INST_ADDR(0), INST_FETCH(1), INST_LOAD(2), IDLE(3), OP_ADDR(4), OP_FETCH(5), ALU_OP(6), STORE(7), HALTED.
  - HALTED drives phase = 3'b000 with halted = 1.
- All outputs are registered Moore decodes of the state plus registered opcode/zero. There is no combinational path from any input to any output.
- Reset (asynchronous, rst_n = 0):
  - State goes to INST_ADDR.
  - Every output reads 0, except pc_active = 1 (instruction address selected).
  - The wait counter and mem_timeout clear.
  - Reset asserted mid-cycle aborts immediately. No write strobe may survive reset.
- INST_ADDR: pc_active = 1, pc_addr = 0. Advances next cycle.
- INST_FETCH: mem_rd = 1, pc_active = 1.
  - Stays while mem_ready = 0, incrementing the wait counter.
  - Leaves on mem_ready = 1.
  - When the counter reaches FETCH_WAIT_MAX: set mem_timeout and advance anyway.
- INST_LOAD: mem_rd = 1, ir_load = 1. Opcode is captured at the end of this cycle.
- IDLE: pc_active = 0 (mux holds). All strobes 0.
- OP_ADDR:
  - pc_inc = 1.
  - If opcode = HLT, next state is HALTED.
  - Else pc_active = 1, and pc_addr = 1 iff opcode is in ALU_OPS or is STO.
- OP_FETCH:
  - For ALU_OPS: mem_rd = 1, with the same mem_ready stall and timeout rule as INST_FETCH.
  - For other opcodes: single cycle, no strobe.
  - pc_addr is held.
- ALU_OP:
  - ALU_OPS: mem_rd = 1.
  - SKZ with zero sampled = 1: pc_inc = 1, skip = 1.
  - JMP: pc_load = 1, skip_signal = 1.
- STORE:
  - ALU_OPS: acc_load = 1.
  - STO: mem_wr = 1 for exactly one cycle.
  - JMP: skip_signal is held at 1.
  - Next state is INST_ADDR.
- HALTED:
  - pc_active = 0, all strobes 0.
  - resume = 1 moves to INST_ADDR next cycle.
  - resume outside HALTED is ignored.
- Mutual-exclusion invariants (assertable):
  - mem_rd and mem_wr never both 1.
  - skip and skip_signal never both 1.
  - pc_inc and pc_load never both 1.
- Cycle length: 8 cycles per instruction with zero stall; each stall cycle adds one.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams (OP_HLT..OP_JMP)
  - phase encodings
  - is_alu_op function
- Sub-module seq_wait_counter: stall counter with saturate, clear, timeout compare and sticky flag. It is instantiated once and shared by both fetch states.

Test Plan:
- Reset, then release with mem_ready tied 1 and ADD (2) in the IR:
  - phase sequence 0..7.
  - pc_addr = 1 during phases 4–6.
  - acc_load = 1 only in phase 7.
  - Next INST_ADDR at cycle 8.
- STO (6): mem_wr = 1 for exactly one cycle in phase 7; mem_rd = 0 throughout phases 4–7.
- SKZ (1) with zero = 1: pc_inc pulses in both phase 4 and phase 6, with skip = 1 in phase 6. Repeat with zero = 0: a single pc_inc pulse and skip = 0.
- JMP (7): pc_load = 1 in phase 6; skip_signal = 1 in phases 6–7; pc_inc = 1 in phase 4 only.
- Fetch stalls:
  - mem_ready = 0 for 3 cycles in INST_FETCH: phase stays 1 for 4 cycles, instruction takes 11 cycles.
  - mem_ready = 0 for 20 cycles: mem_timeout = 1 after 15 stall cycles and stays sticky.
- HLT (0): halted = 1 after phase 4 with all strobes 0. resume pulse leads to INST_ADDR next cycle. rst_n asserted during STORE of an STO clears mem_wr asynchronously.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit RISC core control path: opcodes,
// sequencer states/phases, the registered control word and opcode helpers.
package cpu_pkg;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    localparam logic [2:0] PH_INST_ADDR  = 3'd0;
    localparam logic [2:0] PH_INST_FETCH = 3'd1;
    localparam logic [2:0] PH_INST_LOAD  = 3'd2;
    localparam logic [2:0] PH_IDLE       = 3'd3;
    localparam logic [2:0] PH_OP_ADDR    = 3'd4;
    localparam logic [2:0] PH_OP_FETCH   = 3'd5;
    localparam logic [2:0] PH_ALU_OP     = 3'd6;
    localparam logic [2:0] PH_STORE      = 3'd7;

    // The low three bits of each state equal its phase; HALTED reports phase 0.
    typedef enum logic [3:0] {
        ST_INST_ADDR  = {1'b0, PH_INST_ADDR},
        ST_INST_FETCH = {1'b0, PH_INST_FETCH},
        ST_INST_LOAD  = {1'b0, PH_INST_LOAD},
        ST_IDLE       = {1'b0, PH_IDLE},
        ST_OP_ADDR    = {1'b0, PH_OP_ADDR},
        ST_OP_FETCH   = {1'b0, PH_OP_FETCH},
        ST_ALU_OP     = {1'b0, PH_ALU_OP},
        ST_STORE      = {1'b0, PH_STORE},
        ST_HALTED     = 4'd8
    } state_e;

    // Registered control word; every output of the sequencer comes from here
    // (except the sticky timeout flag, which lives in the wait counter).
    typedef struct packed {
        logic       pc_addr;
        logic       pc_active;
        logic       skip_signal;
        logic       skip;
        logic       mem_rd;
        logic       mem_wr;
        logic       ir_load;
        logic       pc_inc;
        logic       pc_load;
        logic       acc_load;
        logic       halted;
        logic [2:0] phase;
    } ctrl_t;

    // Instructions that read an operand from memory and load the accumulator.
    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

    // Instructions whose operand phase points the mux at the data address.
    function automatic logic uses_data_addr(input logic [2:0] op);
        return is_alu_op(op) || (op == OP_STO);
    endfunction

endpackage

// File: rtl/seq_wait_counter.sv
// Memory-read stall counter shared by both fetch states. Counts cycles spent
// waiting for mem_ready, saturates at WAIT_MAX, and latches a sticky timeout
// flag when a read is still not ready once the limit has been reached.
module seq_wait_counter
#(
    parameter int WAIT_MAX = 15
)(
    input  logic clk,
    input  logic rst_n,
    input  logic stall_i,
    output logic at_max_o,
    output logic timeout_o
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    assign at_max_o  = (cnt_q == CNT_MAX);
    assign timeout_o = timeout_q;

    // Count while stalled, clear as soon as the FSM is not waiting; the FSM
    // gives up on the read in the cycle it sees the counter already at max.
    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (!stall_i) begin
            cnt_d = '0;
        end else if (at_max_o) begin
            timeout_d = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter and sticky flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: rtl/fetch_exec_sequencer.sv
// Instruction-cycle controller: steps the 8-phase fetch/execute sequence,
// stalls on memory reads, and drives registered mux/strobe controls.
//
// state      | meaning
// -----------+----------------------------------------------------------
// INST_ADDR  | present PC on the address mux
// INST_FETCH | read instruction, wait for mem_ready (bounded)
// INST_LOAD  | load IR; opcode captured at end of this cycle
// IDLE       | mux holds, no strobes
// OP_ADDR    | bump PC, select data address for memory-operand ops
// OP_FETCH   | read operand for ALU ops (bounded wait), else one cycle
// ALU_OP     | ALU read / SKZ skip / JMP load PC
// STORE      | accumulator load, STO write, JMP target held
// HALTED     | parked after HLT until resume
module fetch_exec_sequencer
    import cpu_pkg::*;
#(
    parameter int OP_W           = 3,
    parameter int FETCH_WAIT_MAX = 15
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    input  logic            mem_ready,
    input  logic            resume,
    output logic            pc_addr,
    output logic            pc_active,
    output logic            skip_signal,
    output logic            skip,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic            ir_load,
    output logic            pc_inc,
    output logic            pc_load,
    output logic            acc_load,
    output logic            halted,
    output logic [2:0]      phase,
    output logic            mem_timeout
);

    localparam ctrl_t CTRL_RESET = '{pc_active: 1'b1, phase: 3'd0, default: 1'b0};

    state_e          state_q, state_d;
    logic [OP_W-1:0] op_q, op_d;
    logic            zero_q;
    ctrl_t           ctrl_q, ctrl_d;
    logic [2:0]      op;
    logic            in_fetch;
    logic            stall;
    logic            wait_at_max;

    assign op = op_q[2:0];

    assign in_fetch = (state_q == ST_INST_FETCH) ||
                      ((state_q == ST_OP_FETCH) && is_alu_op(op));
    assign stall    = in_fetch && !mem_ready;

    seq_wait_counter #(
        .WAIT_MAX (FETCH_WAIT_MAX)
    ) u_wait (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall_i   (stall),
        .at_max_o  (wait_at_max),
        .timeout_o (mem_timeout)
    );

    // Control word for a given state; decoded one cycle early from the next
    // state so the outputs are flops aligned with the state register.
    function automatic ctrl_t decode(input state_e s, input logic [2:0] o, input logic z);
        ctrl_t c;
        c       = '0;
        c.phase = s[2:0];
        unique case (s)
            ST_INST_ADDR: begin
                c.pc_active = 1'b1;
            end
            ST_INST_FETCH: begin
                c.pc_active = 1'b1;
                c.mem_rd    = 1'b1;
            end
            ST_INST_LOAD: begin
                c.pc_active = 1'b1;
                c.mem_rd    = 1'b1;
                c.ir_load   = 1'b1;
            end
            ST_IDLE: begin
                c.pc_active = 1'b0;
            end
            ST_OP_ADDR: begin
                c.pc_inc = 1'b1;
                if (o != OP_HLT) begin
                    c.pc_active = 1'b1;
                    c.pc_addr   = uses_data_addr(o);
                end
            end
            ST_OP_FETCH: begin
                c.pc_active = 1'b1;
                c.pc_addr   = uses_data_addr(o);
                c.mem_rd    = is_alu_op(o);
            end
            ST_ALU_OP: begin
                c.pc_active = 1'b1;
                c.pc_addr   = uses_data_addr(o);
                c.mem_rd    = is_alu_op(o);
                if ((o == OP_SKZ) && z) begin
                    c.pc_inc = 1'b1;
                    c.skip   = 1'b1;
                end
                if (o == OP_JMP) begin
                    c.pc_load     = 1'b1;
                    c.skip_signal = 1'b1;
                end
            end
            ST_STORE: begin
                c.pc_active   = 1'b1;
                c.pc_addr     = (o == OP_STO);
                c.acc_load    = is_alu_op(o);
                c.mem_wr      = (o == OP_STO);
                c.skip_signal = (o == OP_JMP);
            end
            ST_HALTED: begin
                c.halted = 1'b1;
                c.phase  = PH_INST_ADDR;
            end
            default: c = CTRL_RESET;
        endcase
        return c;
    endfunction

    // Next-state logic, opcode capture and next control word.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        unique case (state_q)
            ST_INST_ADDR:  state_d = ST_INST_FETCH;
            ST_INST_FETCH: if (mem_ready || wait_at_max) state_d = ST_INST_LOAD;
            ST_INST_LOAD: begin
                op_d    = opcode;
                state_d = ST_IDLE;
            end
            ST_IDLE:       state_d = ST_OP_ADDR;
            ST_OP_ADDR:    state_d = (op == OP_HLT) ? ST_HALTED : ST_OP_FETCH;
            ST_OP_FETCH: begin
                if (!is_alu_op(op) || mem_ready || wait_at_max) state_d = ST_ALU_OP;
            end
            ST_ALU_OP:     state_d = ST_STORE;
            ST_STORE:      state_d = ST_INST_ADDR;
            ST_HALTED:     if (resume) state_d = ST_INST_ADDR;
            default:       state_d = ST_INST_ADDR;
        endcase
        ctrl_d = decode(state_d, op, zero_q);
    end

    // State, captured opcode/zero and registered control word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INST_ADDR;
            op_q    <= '0;
            zero_q  <= 1'b0;
            ctrl_q  <= CTRL_RESET;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            zero_q  <= zero;
            ctrl_q  <= ctrl_d;
        end
    end

    assign pc_addr     = ctrl_q.pc_addr;
    assign pc_active   = ctrl_q.pc_active;
    assign skip_signal = ctrl_q.skip_signal;
    assign skip        = ctrl_q.skip;
    assign mem_rd      = ctrl_q.mem_rd;
    assign mem_wr      = ctrl_q.mem_wr;
    assign ir_load     = ctrl_q.ir_load;
    assign pc_inc      = ctrl_q.pc_inc;
    assign pc_load     = ctrl_q.pc_load;
    assign acc_load    = ctrl_q.acc_load;
    assign halted      = ctrl_q.halted;
    assign phase       = ctrl_q.phase;

endmodule

// File: tb/tb_fetch_exec_sequencer.sv
// Bench for fetch_exec_sequencer: a per-instruction cycle model builds the
// expected phase/strobe timeline, one process compares every cycle.
module tb_fetch_exec_sequencer;

    localparam int FWM = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] opcode = 3'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       resume = 1'b0;
    logic       pc_addr, pc_active, skip_signal, skip, mem_rd, mem_wr;
    logic       ir_load, pc_inc, pc_load, acc_load, halted, mem_timeout;
    logic [2:0] phase;

    always #5 clk = ~clk;

    fetch_exec_sequencer #(.OP_W(3), .FETCH_WAIT_MAX(FWM)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .resume(resume),
        .pc_addr(pc_addr), .pc_active(pc_active), .skip_signal(skip_signal),
        .skip(skip), .mem_rd(mem_rd), .mem_wr(mem_wr), .ir_load(ir_load),
        .pc_inc(pc_inc), .pc_load(pc_load), .acc_load(acc_load),
        .halted(halted), .phase(phase), .mem_timeout(mem_timeout)
    );

    // bits: 14:12 phase, 11 halted, 10 pc_addr, 9 pc_active, 8 skip_signal,
    // 7 skip, 6 mem_rd, 5 mem_wr, 4 ir_load, 3 pc_inc, 2 pc_load, 1 acc_load, 0 timeout
    wire [14:0] act_vec = {phase, halted, pc_addr, pc_active, skip_signal, skip,
                           mem_rd, mem_wr, ir_load, pc_inc, pc_load, acc_load, mem_timeout};

    typedef struct {
        int       ph;
        bit       h;
        bit       rdy;
        bit       res;
        bit [2:0] op;
        bit       z;
        bit       to;
    } step_t;

    step_t      q[$];
    bit         model_to = 1'b0;
    int         checks = 0;
    int         failures = 0;
    bit         check_en = 1'b0;
    logic [14:0] exp_vec = '0;
    int         n_wr = 0, n_pcload = 0, n_skip = 0, n_inc = 0, n_acc = 0, n_halt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected outputs for a phase of an instruction, straight from the
    // per-phase rules of the instruction cycle.
    function automatic logic [14:0] expect_out(input int ph, input bit h, input bit [2:0] op,
                                               input bit z, input bit to);
        bit alu, data, skz, e_addr, e_act, e_ss, e_skip, e_rd, e_wr, e_ir, e_inc, e_ld, e_acc;
        logic [2:0] p;
        if (h) return {3'd0, 1'b1, 10'd0, to};
        p      = ph[2:0];
        alu    = (op >= 3'd2) && (op <= 3'd5);
        data   = alu || (op == 3'd6);
        skz    = (op == 3'd1) && z;
        e_act  = !((ph == 3) || (ph == 4 && op == 3'd0));
        e_addr = (data && ph >= 4 && ph <= 6) || (op == 3'd6 && ph == 7);
        e_ss   = (op == 3'd7) && (ph == 6 || ph == 7);
        e_skip = skz && ph == 6;
        e_rd   = (ph == 1 || ph == 2) || (alu && (ph == 5 || ph == 6));
        e_wr   = (op == 3'd6) && ph == 7;
        e_ir   = ph == 2;
        e_inc  = ph == 4 || (skz && ph == 6);
        e_ld   = (op == 3'd7) && ph == 6;
        e_acc  = alu && ph == 7;
        return {p, 1'b0, e_addr, e_act, e_ss, e_skip, e_rd, e_wr, e_ir, e_inc, e_ld, e_acc, to};
    endfunction

    task automatic push(input int ph, input bit h, input bit rdy, input bit res,
                        input bit [2:0] op, input bit z);
        step_t s;
        s.ph = ph; s.h = h; s.rdy = rdy; s.res = res; s.op = op; s.z = z; s.to = model_to;
        q.push_back(s);
    endtask

    // Fetch wait: stay while not ready; after FWM waiting cycles give up.
    task automatic push_fetch(input int ph, input int nstall, input bit [2:0] op, input bit z);
        for (int j = 0; j <= FWM; j++) begin
            push(ph, 1'b0, (j >= nstall), 1'b0, op, z);
            if (j >= nstall) break;
            if (j == FWM) model_to = 1'b1;
        end
    endtask

    task automatic build(input bit [2:0] op, input bit z, input int istall, input int ostall,
                         input int hcyc, input int ign_res_ph, output int len);
        int n0;
        bit alu;
        n0  = q.size();
        alu = (op >= 3'd2) && (op <= 3'd5);
        push(0, 1'b0, 1'b1, ign_res_ph == 0, op, z);
        push_fetch(1, istall, op, z);
        for (int p = 2; p <= 4; p++) push(p, 1'b0, 1'b1, ign_res_ph == p, op, z);
        if (op == 3'd0) begin
            for (int k = 0; k < hcyc; k++) push(0, 1'b1, 1'b1, k == hcyc - 1, op, z);
        end else begin
            if (alu) push_fetch(5, ostall, op, z);
            else     push(5, 1'b0, 1'b1, 1'b0, op, z);
            push(6, 1'b0, 1'b1, 1'b0, op, z);
            push(7, 1'b0, 1'b1, 1'b0, op, z);
        end
        len = q.size() - n0;
    endtask

    task automatic apply(input step_t s);
        opcode    = s.op;
        zero      = s.z;
        mem_ready = s.rdy;
        resume    = s.res;
        exp_vec   = expect_out(s.ph, s.h, s.op, s.z, s.to);
        check_en  = 1'b1;
    endtask

    task automatic run_steps(input int leave);
        step_t s;
        while (q.size() > leave) begin
            s = q.pop_front();
            apply(s);
            @(posedge clk); #1;
        end
    endtask

    // Per-cycle comparison against the model plus invariants and pulse tallies.
    always @(negedge clk) begin
        if (check_en) begin
            check("cycle_outputs", {17'd0, act_vec}, {17'd0, exp_vec});
            check("excl_rd_wr", {31'd0, mem_rd & mem_wr}, 32'd0);
            check("excl_skip", {31'd0, skip & skip_signal}, 32'd0);
            check("excl_inc_load", {31'd0, pc_inc & pc_load}, 32'd0);
            n_wr     += int'(mem_wr);
            n_pcload += int'(pc_load);
            n_skip   += int'(skip);
            n_inc    += int'(pc_inc);
            n_acc    += int'(acc_load);
            n_halt   += int'(halted);
        end
    end

    initial begin
        int    len;
        step_t s;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_vector", {17'd0, act_vec}, 32'h0200);
        check("reset_vs_model", {17'd0, act_vec}, {17'd0, expect_out(0, 0, 3'd0, 0, 0)});
        rst_n = 1'b1;

        build(3'd2, 0, 0, 0, 0, -1, len);  check("len_add", len, 8);
        build(3'd6, 0, 0, 0, 0, -1, len);  check("len_sto", len, 8);
        build(3'd1, 1, 0, 0, 0, -1, len);  check("len_skz1", len, 8);
        build(3'd1, 0, 0, 0, 0, -1, len);  check("len_skz0", len, 8);
        build(3'd7, 0, 0, 0, 0, -1, len);  check("len_jmp", len, 8);
        build(3'd2, 1, 3, 0, 0, -1, len);  check("len_add_stall3", len, 11);
        build(3'd5, 0, 0, 2, 0, -1, len);  check("len_lda_opstall2", len, 10);
        build(3'd4, 0, 20, 0, 0, -1, len); check("len_xor_timeout", len, 23);
        build(3'd3, 0, 0, 0, 0, 3, len);   check("len_and_resume_ign", len, 8);
        build(3'd0, 0, 0, 0, 4, -1, len);  check("len_hlt", len, 9);
        build(3'd2, 0, 0, 0, 0, -1, len);  check("len_add_after", len, 8);
        run_steps(0);

        check("count_mem_wr", n_wr, 1);
        check("count_pc_load", n_pcload, 1);
        check("count_skip", n_skip, 1);
        check("count_pc_inc", n_inc, 12);
        check("count_acc_load", n_acc, 6);
        check("count_halted", n_halt, 4);

        // STO interrupted by reset in the middle of its write cycle.
        build(3'd6, 0, 0, 0, 0, -1, len);
        run_steps(1);
        s = q.pop_front();
        apply(s);
        @(negedge clk); #1;
        check_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_clears_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_async_vector", {17'd0, act_vec}, 32'h0200);
        @(posedge clk); #1;
        check("rst_held_vector", {17'd0, act_vec}, 32'h0200);
        rst_n    = 1'b1;
        model_to = 1'b0;
        build(3'd2, 0, 0, 0, 0, -1, len);
        run_steps(0);
        check_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
